vote_result_reporter: RTL

//  Read side of the vote tally: on request in result mode, snapshots count1..count4 from the vote unit.

---
 rtl/vote_result_reporter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vote_result_reporter.sv
// Result reporter for the vote tally. On an accepted request in result mode it
// snapshots the four counts, resolves the winner, then streams a 7-byte frame
// (sync, count1..count4, winner, XOR checksum) over a valid/ready byte port.
module vote_result_reporter #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned GAP_CYC   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       report_req,
    input  logic [7:0] count1,
    input  logic [7:0] count2,
    input  logic [7:0] count3,
    input  logic [7:0] count4,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [2:0] winner,
    output logic       tie
);

    localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned LAST_IDX = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         snap [4];
    logic [7:0]         chk;
    logic [IDX_W-1:0]   idx;
    logic [GAP_W-1:0]   gap_cnt;

    logic               accept_c;
    logic               xfer_c;
    logic               last_c;
    logic [7:0]         max_c;
    logic [2:0]         n_max_c;
    logic [2:0]         win_idx_c;
    logic [2:0]         winner_c;
    logic               tie_c;
    logic [7:0]         checksum_c;
    logic [IDX_W-1:0]   idx_nxt_c;
    logic [7:0]         next_byte_c;

    assign accept_c  = report_req && mode;
    assign xfer_c    = tx_valid && tx_ready;
    assign last_c    = (idx == IDX_W'(LAST_IDX));
    assign idx_nxt_c = idx + IDX_W'(1);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; requests outside IDLE are simply dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept_c) state_nxt = CALC;
            CALC: state_nxt = SEND;
            SEND: begin
                if (xfer_c && last_c) begin
                    state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
                end
            end
            GAP:  if (gap_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Winner resolution from the snapshot: unique nonzero max wins, shared max is a tie.
    always_comb begin
        max_c     = '0;
        n_max_c   = '0;
        win_idx_c = '0;
        winner_c  = '0;
        tie_c     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (snap[i] > max_c) max_c = snap[i];
        end
        for (int i = 0; i < 4; i++) begin
            if (snap[i] == max_c) begin
                n_max_c   = n_max_c + 3'd1;
                win_idx_c = 3'(i + 1);
            end
        end
        if (max_c != '0) begin
            if (n_max_c == 3'd1) begin
                winner_c = win_idx_c;
            end else begin
                tie_c = 1'b1;
            end
        end
        checksum_c = SYNC_BYTE ^ snap[0] ^ snap[1] ^ snap[2] ^ snap[3] ^ {5'b0, winner_c};
    end

    // Byte that follows the one currently presented.
    always_comb begin
        next_byte_c = SYNC_BYTE;
        case (idx_nxt_c)
            3'd1:    next_byte_c = snap[0];
            3'd2:    next_byte_c = snap[1];
            3'd3:    next_byte_c = snap[2];
            3'd4:    next_byte_c = snap[3];
            3'd5:    next_byte_c = {5'b0, winner};
            3'd6:    next_byte_c = chk;
            default: next_byte_c = SYNC_BYTE;
        endcase
    end

    // Snapshot, result registers and the byte stream.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) snap[i] <= '0;
            chk      <= '0;
            idx      <= '0;
            gap_cnt  <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            winner   <= '0;
            tie      <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        snap[0] <= count1;
                        snap[1] <= count2;
                        snap[2] <= count3;
                        snap[3] <= count4;
                    end
                end
                CALC: begin
                    winner   <= winner_c;
                    tie      <= tie_c;
                    chk      <= checksum_c;
                    idx      <= '0;
                    tx_data  <= SYNC_BYTE;
                    tx_valid <= 1'b1;
                end
                SEND: begin
                    if (xfer_c) begin
                        if (last_c) begin
                            tx_valid <= 1'b0;
                            gap_cnt  <= GAP_W'(GAP_CYC - 1);
                        end else begin
                            idx     <= idx_nxt_c;
                            tx_data <= next_byte_c;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
